serial_divider_core: RTL and testbench

Iterative restoring divider engine that sits directly downstream of the Wishbone divider register block. It receives the one-cycle start pulse and the latched dividend/divisor from that block, and produces one quotient bit per clock. It returns quotient, remainder and status for the register block to capture. There is no bus interface; the block is a pure datapath plus FSM.

---
 rtl/serial_divider_core.sv | 212 +++++++++++++++++++++
 tb/tb_serial_divider_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_divider_core.sv
// Iterative restoring divider: one quotient bit per clock, XLEN+1 cycles from start to done.
// Optional signed mode is built only when SERIAL_DIV_SIGNED_EN is defined.
module serial_divider_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            signed_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            div_zero_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [XLEN-1:0]   dvd_shift_r;
  logic [XLEN-1:0]   dvs_r;
  logic [XLEN-1:0]   orig_dvd_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-2:0]   quo_r;
  logic [CW-1:0]     cnt_r;
  logic              dvs_zero_r;
  logic              accept_s;
  logic [XLEN-1:0]   dvd_mag_s;
  logic [XLEN-1:0]   dvs_mag_s;
  logic [XLEN:0]     r_shift_s;
  logic [XLEN-1:0]   diff_s;
  logic              ge_s;
  logic [XLEN-1:0]   rem_next_s;
  logic [XLEN-1:0]   quo_next_s;
  logic [XLEN-1:0]   q_sgn_s;
  logic [XLEN-1:0]   r_sgn_s;
  logic [XLEN-1:0]   q_fin_s;
  logic [XLEN-1:0]   r_fin_s;

  assign accept_s = (state_r == IDLE) && start_i;

`ifdef SERIAL_DIV_SIGNED_EN
  localparam logic [XLEN-1:0] ONE = XLEN'(1'b1);

  logic neg_q_s;
  logic neg_r_s;
  logic neg_q_r;
  logic neg_r_r;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + ONE;
  endfunction

  // Operand magnitudes and result-sign flags at entry
  always_comb begin
    dvd_mag_s = dividend_i;
    dvs_mag_s = divisor_i;
    neg_q_s   = 1'b0;
    neg_r_s   = 1'b0;
    if (signed_i) begin
      dvd_mag_s = dividend_i[XLEN-1] ? negate(dividend_i) : dividend_i;
      dvs_mag_s = divisor_i[XLEN-1] ? negate(divisor_i) : divisor_i;
      neg_q_s   = dividend_i[XLEN-1] ^ divisor_i[XLEN-1];
      neg_r_s   = dividend_i[XLEN-1];
    end else begin
      dvd_mag_s = dividend_i;
      dvs_mag_s = divisor_i;
    end
  end

  // Sign flags captured with the operands
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
    end else begin
      neg_q_r <= neg_q_r;
      neg_r_r <= neg_r_r;
    end
  end

  // Sign correction applied to the final iteration's result
  always_comb begin
    q_sgn_s = neg_q_r ? negate(quo_next_s) : quo_next_s;
    r_sgn_s = neg_r_r ? negate(rem_next_s) : rem_next_s;
  end
`else
  logic unused_signed_s;

  assign unused_signed_s = signed_i;
  assign dvd_mag_s       = dividend_i;
  assign dvs_mag_s       = divisor_i;
  assign q_sgn_s         = quo_next_s;
  assign r_sgn_s         = rem_next_s;
`endif

  // One restoring step; R stays below the divisor so the difference fits XLEN bits
  always_comb begin
    r_shift_s  = {rem_r, dvd_shift_r[XLEN-1]};
    ge_s       = (r_shift_s >= {1'b0, dvs_r});
    diff_s     = r_shift_s[XLEN-1:0] - dvs_r;
    rem_next_s = ge_s ? diff_s : r_shift_s[XLEN-1:0];
    quo_next_s = {quo_r, ge_s};
  end

  // Zero divisor overrides whatever the datapath produced
  always_comb begin
    if (dvs_zero_r) begin
      q_fin_s = ONES;
      r_fin_s = orig_dvd_r;
    end else begin
      q_fin_s = q_sgn_s;
      r_fin_s = r_sgn_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start_i ? CALC : IDLE;
      CALC:    state_nx_s = (cnt_r == CNT_ZERO) ? DONE : CALC;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; results load on the last CALC edge so done_o is seen in DONE
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dvd_shift_r <= ZERO;
      dvs_r       <= ZERO;
      orig_dvd_r  <= ZERO;
      rem_r       <= ZERO;
      quo_r       <= {(XLEN-1){1'b0}};
      cnt_r       <= CNT_ZERO;
      dvs_zero_r  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= ZERO;
      remainder_o <= ZERO;
      div_zero_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            dvd_shift_r <= dvd_mag_s;
            dvs_r       <= dvs_mag_s;
            orig_dvd_r  <= dividend_i;
            dvs_zero_r  <= (divisor_i == ZERO);
            rem_r       <= ZERO;
            quo_r       <= {(XLEN-1){1'b0}};
            cnt_r       <= CNT_LOAD;
            busy_o      <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        CALC: begin
          rem_r       <= rem_next_s;
          quo_r       <= quo_next_s[XLEN-2:0];
          dvd_shift_r <= {dvd_shift_r[XLEN-2:0], 1'b0};
          cnt_r       <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ZERO) begin
            quotient_o  <= q_fin_s;
            remainder_o <= r_fin_s;
            div_zero_o  <= dvs_zero_r;
            done_o      <= 1'b1;
          end else begin
            done_o <= 1'b0;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider_core.sv
// Directed bench for serial_divider_core: vector table plus hand-written busy/reset sequences.
// Expected values follow the SERIAL_DIV_SIGNED_EN setting of the build.
`timescale 1ns/1ps
module tb_serial_divider_core;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        signed_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_zero_o;

  int checks = 0;
  int errors = 0;

  serial_divider_core #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .signed_i    (signed_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive a start pulse during cycle 0 (sampled at the following rising edge)
  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn);
    @(negedge clk_i);
    dividend_i = dvd;
    divisor_i  = dvs;
    signed_i   = sgn;
    start_i    = 1'b1;
  endtask

  // Observe cycles 1..34 after a start: report the done cycle and busy/done shape
  task automatic run_timing(output int done_cyc, output int done_cnt, output bit busy_ok);
    done_cyc = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (busy_o !== (c <= 33)) busy_ok = 1'b0;
      if (c == 1) start_i = 1'b0;
    end
  endtask

  initial begin
    int  dc;
    int  dn;
    bit  bok;
    int  late_done;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'h0000_1234,  32'h0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[2] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[3] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
    vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
    vecs[5] = '{32'h1234_5678,  32'h0000_0100,  1'b0, 32'h0012_3456,  32'h0000_0078,  1'b0};
    vecs[6] = '{32'hFFFF_FFF9,  32'h0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
`ifdef SERIAL_DIV_SIGNED_EN
    vecs[7]  = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0,          1'b0};
    vecs[9]  = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[10] = '{32'd100,       32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0};
`else
    vecs[7]  = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h0,          32'h8000_0000,  1'b0};
    vecs[9]  = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'h2492_4916,  32'd2,          1'b0};
    vecs[10] = '{32'd100,       32'hFFFF_FFF9,  1'b1, 32'h0,          32'd100,        1'b0};
`endif

    reset_i    = 1'b1;
    start_i    = 1'b0;
    dividend_i = 32'h0;
    divisor_i  = 32'h0;
    signed_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset busy", {31'h0, busy_o}, 32'h0);
    check("reset done", {31'h0, done_o}, 32'h0);
    check("reset quotient", quotient_o, 32'h0);
    check("reset remainder", remainder_o, 32'h0);
    check("reset div_zero", {31'h0, div_zero_o}, 32'h0);
    reset_i = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn);
      run_timing(dc, dn, bok);
      check($sformatf("vec%0d done cycle", i), dc, 32'd33);
      check($sformatf("vec%0d done pulses", i), dn, 32'd1);
      check($sformatf("vec%0d busy shape", i), {31'h0, bok}, 32'h1);
      check($sformatf("vec%0d quotient", i), quotient_o, vecs[i].q);
      check($sformatf("vec%0d remainder", i), remainder_o, vecs[i].r);
      check($sformatf("vec%0d div_zero", i), {31'h0, div_zero_o}, {31'h0, vecs[i].z});
    end

    // Start while busy is ignored; a start in cycle 34 is accepted
    start_op(32'd100, 32'd7, 1'b0);
    dn = 0;
    late_done = -1;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        dn++;
        if (c != 33) late_done = c;
      end
      if (c == 33) begin
        check("busy-start done", {31'h0, done_o}, 32'h1);
        check("busy-start quotient", quotient_o, 32'd14);
        check("busy-start remainder", remainder_o, 32'd2);
      end
      if (c == 50) check("held quotient", quotient_o, 32'd14);
      if (c == 67) begin
        check("second done", {31'h0, done_o}, 32'h1);
        check("second quotient", quotient_o, 32'hFFFF_FFFF);
        check("second remainder", remainder_o, 32'd10);
        check("second div_zero", {31'h0, div_zero_o}, 32'h1);
      end
      start_i = 1'b0;
      if (c == 10) begin
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
      end
      if (c == 34) begin
        dividend_i = 32'd10;
        divisor_i  = 32'd0;
        start_i    = 1'b1;
      end
    end
    check("busy-start done count", dn, 32'd2);
    check("second done cycle", late_done, 32'd67);

    // Asynchronous reset mid-operation
    start_op(32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #2 reset_i = 1'b1;
    #1;
    check("midreset busy", {31'h0, busy_o}, 32'h0);
    check("midreset quotient", quotient_o, 32'h0);
    check("midreset remainder", remainder_o, 32'h0);
    check("midreset div_zero", {31'h0, div_zero_o}, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1 || busy_o === 1'b1) dn++;
    end
    check("no activity after reset", dn, 32'd0);
    start_op(32'd9, 32'd3, 1'b0);
    run_timing(dc, dn, bok);
    check("post-reset done cycle", dc, 32'd33);
    check("post-reset quotient", quotient_o, 32'd3);
    check("post-reset remainder", remainder_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
